// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle, word-organised data memory behind a valid/ready
// request and a one-cycle response pulse. Supports RV32I byte/half/word loads
// and stores with sign/zero extension, fault reporting and a pipeline stall.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic        fire;

  logic [31:0] mem_q [DEPTH_WORDS];

  // Decoded view of the latched request.
  logic [29:0]      word_idx;
  logic [1:0]       lane;
  logic [IDX_W-1:0] mem_idx;
  logic             is_half;
  logic             is_word;
  logic             bad_f3;
  logic             misaligned;
  logic             out_of_range;
  logic             acc_err;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_data;
  logic [3:0]       byte_en;
  logic [31:0]      wr_data;

  assign req_ready = (state_q == IDLE);
  assign fire      = req_valid & req_ready;
  assign stall     = ((state_q == IDLE) & req_valid) | (state_q == WAIT);

  // Next-state and latency counter logic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          if (LATENCY > 1) begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and request-latch registers; reset abandons any access.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fire) begin
        write_q  <= req_write;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
      end
    end
  end

  // Access decode, fault detection, load extraction and store lane steering.
  always_comb begin
    word_idx     = addr_q[31:2];
    lane         = addr_q[1:0];
    mem_idx      = word_idx[IDX_W-1:0];
    is_half      = (funct3_q[1:0] == 2'b01);
    is_word      = (funct3_q[1:0] == 2'b10);
    if (write_q) bad_f3 = funct3_q[2] | (funct3_q[1:0] == 2'b11);
    else         bad_f3 = (funct3_q == 3'b011) | (funct3_q[2:1] == 2'b11);
    misaligned   = (is_half & lane[0]) | (is_word & (lane != 2'b00));
    out_of_range = ({2'b00, word_idx} >= 32'(DEPTH_WORDS));
    acc_err      = bad_f3 | misaligned | out_of_range;

    rd_word = mem_q[mem_idx];
    rd_byte = rd_word[{lane, 3'b000} +: 8];
    rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

    load_data = '0;
    unique case (funct3_q)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'h0, rd_byte};
      3'b101:  load_data = {16'h0, rd_half};
      default: load_data = '0;
    endcase

    byte_en = '0;
    wr_data = '0;
    unique case (funct3_q)
      3'b000: begin
        byte_en = 4'b0001 << lane;
        wr_data = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      3'b010: begin
        byte_en = 4'b1111;
        wr_data = wdata_q;
      end
      default: begin
        byte_en = '0;
        wr_data = '0;
      end
    endcase
  end

  // Backing array: stores commit only in the RESP cycle of a legal store.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; its contents are undefined until written,
    // which keeps it mappable onto plain RAM.
    if ((state_q == RESP) && write_q && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_q[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & acc_err;
  assign resp_rdata = (resp_valid & ~acc_err & ~write_q) ? load_data : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: exercises two responders (LATENCY=2 and LATENCY=1)
// against a byte-addressed reference model of the memory.
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_funct3 [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        stall      [2];

  logic [7:0]  mem_m [2][DEPTH*4];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .stall(stall[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .stall(stall[1])
  );

  // Reference model: memory as a little-endian byte array.
  function automatic void model_access(input int w, input bit wr, input logic [31:0] a,
                                       input logic [31:0] d, input logic [2:0] f3,
                                       output logic [31:0] r, output bit e);
    int nbytes = 1;
    bit sgn    = 1'b0;
    bit legal  = 1'b1;
    r = 32'h0;
    e = 1'b0;
    case (f3)
      3'd0:    begin nbytes = 1; sgn = 1'b1; end
      3'd1:    begin nbytes = 2; sgn = 1'b1; end
      3'd2:    nbytes = 4;
      3'd4:    begin nbytes = 1; legal = !wr; end
      3'd5:    begin nbytes = 2; legal = !wr; end
      default: legal = 1'b0;
    endcase
    if (!legal || (a % nbytes) != 0 || (a / 4) >= DEPTH) begin
      e = 1'b1;
    end else if (wr) begin
      for (int i = 0; i < nbytes; i++) mem_m[w][a + i] = d[8*i +: 8];
    end else begin
      for (int i = 0; i < nbytes; i++) r[8*i +: 8] = mem_m[w][a + i];
      if (sgn && nbytes < 4 && r[8*nbytes-1]) r = r | (32'hFFFF_FFFF << (8*nbytes));
    end
  endfunction

  task automatic drive(input int w, input bit v, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f3);
    req_valid[w]  = v;
    req_write[w]  = wr;
    req_addr[w]   = a;
    req_wdata[w]  = d;
    req_funct3[w] = f3;
  endtask

  // One complete transaction with cycle-exact handshake/stall/response checks.
  task automatic access(input int w, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f3, output logic [31:0] obs_r, output bit obs_e);
    logic [31:0] exp_r;
    bit          exp_e;
    logic [2:0]  obs_ctl;
    int          lat;
    lat = (w == 0) ? 2 : 1;
    @(negedge clk);
    drive(w, 1'b1, wr, a, d, f3);
    #1;
    n_checks++;
    obs_ctl = {req_ready[w], stall[w], resp_valid[w]};
    if (obs_ctl !== 3'b110) begin
      n_errors++;
      $display("FAIL accept_ctl inst%0d addr=%h: {ready,stall,valid}=%b expected 110", w, a, obs_ctl);
    end
    model_access(w, wr, a, d, f3, exp_r, exp_e);
    @(posedge clk);
    obs_r = 32'h0;
    obs_e = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) drive(w, 1'b0, $urandom_range(0, 1), $urandom, $urandom, 3'($urandom));
      #1;
      n_checks++;
      obs_ctl = {req_ready[w], stall[w], resp_valid[w]};
      if (k < lat) begin
        if (obs_ctl !== 3'b010) begin
          n_errors++;
          $display("FAIL wait_ctl inst%0d k=%0d: {ready,stall,valid}=%b expected 010", w, k, obs_ctl);
        end
      end else begin
        if (obs_ctl !== 3'b001) begin
          n_errors++;
          $display("FAIL resp_ctl inst%0d: {ready,stall,valid}=%b expected 001", w, obs_ctl);
        end
        obs_r = resp_rdata[w];
        obs_e = resp_err[w];
        n_checks++;
        if (obs_r !== exp_r || obs_e !== exp_e) begin
          n_errors++;
          $display("FAIL resp_data inst%0d wr=%0d f3=%0d addr=%h: rdata=%h err=%b expected rdata=%h err=%b",
                   w, wr, f3, a, obs_r, obs_e, exp_r, exp_e);
        end
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({req_ready[w], stall[w], resp_valid[w], resp_err[w]} !== 4'b1000 || resp_rdata[w] !== 32'h0) begin
      n_errors++;
      $display("FAIL post_resp inst%0d: ready=%b stall=%b valid=%b err=%b rdata=%h expected 1 0 0 0 0",
               w, req_ready[w], stall[w], resp_valid[w], resp_err[w], resp_rdata[w]);
    end
  endtask

  task automatic test_reset();
    for (int w = 0; w < 2; w++) drive(w, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    reset = 1'b0;
    #12;
    for (int w = 0; w < 2; w++) begin
      n_checks++;
      if ({req_ready[w], stall[w], resp_valid[w], resp_err[w]} !== 4'b1000 || resp_rdata[w] !== 32'h0) begin
        n_errors++;
        $display("FAIL reset_state inst%0d: ready=%b stall=%b valid=%b err=%b rdata=%h expected 1 0 0 0 0",
                 w, req_ready[w], stall[w], resp_valid[w], resp_err[w], resp_rdata[w]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_fill();
    logic [31:0] r;
    bit e;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < DEPTH; i++) access(w, 1'b1, 32'(i * 4), $urandom, 3'd2, r, e);
  endtask

  task automatic test_store_load();
    logic [31:0] r;
    bit e;
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, r, e);
    access(0, 1'b0, 32'h10, 32'h0, 3'd2, r, e);
    n_checks++;
    if (r !== 32'hDEADBEEF || e !== 1'b0) begin
      n_errors++;
      $display("FAIL sw_lw: rdata=%h err=%b expected deadbeef 0", r, e);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] r;
    bit e;
    access(0, 1'b1, 32'h20, 32'h0, 3'd2, r, e);
    access(0, 1'b1, 32'h21, 32'hFFFFFF80, 3'd0, r, e);
    access(0, 1'b0, 32'h21, 32'h0, 3'd0, r, e);
    n_checks++;
    if (r !== 32'hFFFFFF80) begin n_errors++; $display("FAIL lb: rdata=%h expected ffffff80", r); end
    access(0, 1'b0, 32'h21, 32'h0, 3'd4, r, e);
    n_checks++;
    if (r !== 32'h00000080) begin n_errors++; $display("FAIL lbu: rdata=%h expected 00000080", r); end
    access(0, 1'b0, 32'h20, 32'h0, 3'd2, r, e);
    n_checks++;
    if (r !== 32'h00008000) begin n_errors++; $display("FAIL lw_lane: rdata=%h expected 00008000", r); end
  endtask

  task automatic test_errors();
    logic [31:0] r;
    bit e;
    access(0, 1'b1, 32'h13, 32'h1234, 3'd1, r, e);
    n_checks++;
    if (e !== 1'b1 || r !== 32'h0) begin
      n_errors++;
      $display("FAIL sh_misaligned: err=%b rdata=%h expected 1 0", e, r);
    end
    access(0, 1'b0, 32'h10, 32'h0, 3'd2, r, e);
    n_checks++;
    if (r !== 32'hDEADBEEF) begin n_errors++; $display("FAIL lw_after_err: rdata=%h expected deadbeef", r); end
    access(0, 1'b0, 32'h400, 32'h0, 3'd2, r, e);
    n_checks++;
    if (e !== 1'b1 || r !== 32'h0) begin n_errors++; $display("FAIL lw_range: err=%b rdata=%h expected 1 0", e, r); end
    access(0, 1'b0, 32'h10, 32'h0, 3'd3, r, e);
    n_checks++;
    if (e !== 1'b1) begin n_errors++; $display("FAIL f3_011: err=%b expected 1", e); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] r;
    bit e;
    access(0, 1'b1, 32'h30, 32'hA5A5A5A5, 3'd2, r, e);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h30, 32'h55, 3'd2);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    #1;
    n_checks++;
    if (stall[0] !== 1'b1) begin n_errors++; $display("FAIL abort_wait: stall=%b expected 1", stall[0]); end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({req_ready[0], stall[0], resp_valid[0]} !== 3'b100) begin
      n_errors++;
      $display("FAIL abort_async: {ready,stall,valid}=%b expected 100", {req_ready[0], stall[0], resp_valid[0]});
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (resp_valid[0] !== 1'b0) begin n_errors++; $display("FAIL abort_noresp: valid=%b expected 0", resp_valid[0]); end
    reset = 1'b1;
    access(0, 1'b0, 32'h30, 32'h0, 3'd2, r, e);
    n_checks++;
    if (r !== 32'hA5A5A5A5) begin n_errors++; $display("FAIL abort_nowrite: rdata=%h expected a5a5a5a5", r); end
  endtask

  task automatic test_back_to_back();
    localparam int N = 8;
    logic [31:0] a     [N];
    logic [2:0]  f3    [N];
    logic [31:0] exp_r [N];
    bit          exp_e [N];
    logic [2:0]  legal_f3 [5];
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < N; i++) begin
      a[i]  = 32'($urandom_range(0, DEPTH - 1) * 4);
      f3[i] = legal_f3[$urandom_range(0, 4)];
      model_access(1, 1'b0, a[i], 32'h0, f3[i], exp_r[i], exp_e[i]);
    end
    @(negedge clk);
    drive(1, 1'b1, 1'b0, a[0], 32'h0, f3[0]);
    for (int i = 0; i < N; i++) begin
      #1;
      n_checks++;
      if ({req_ready[1], stall[1], resp_valid[1]} !== 3'b110) begin
        n_errors++;
        $display("FAIL b2b_accept i=%0d: {ready,stall,valid}=%b expected 110", i, {req_ready[1], stall[1], resp_valid[1]});
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({req_ready[1], stall[1], resp_valid[1]} !== 3'b001 || resp_rdata[1] !== exp_r[i] || resp_err[1] !== exp_e[i]) begin
        n_errors++;
        $display("FAIL b2b_resp i=%0d: ctl=%b rdata=%h err=%b expected 001 %h %b", i,
                 {req_ready[1], stall[1], resp_valid[1]}, resp_rdata[1], resp_err[1], exp_r[i], exp_e[i]);
      end
      if (i < N - 1) drive(1, 1'b1, 1'b0, a[i+1], 32'h0, f3[i+1]);
      else           drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
      @(negedge clk);
    end
    #1;
    n_checks++;
    if ({req_ready[1], stall[1], resp_valid[1]} !== 3'b100) begin
      n_errors++;
      $display("FAIL b2b_end: {ready,stall,valid}=%b expected 100", {req_ready[1], stall[1], resp_valid[1]});
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [31:0] a;
    bit e;
    int idx;
    for (int n = 0; n < 300; n++) begin
      idx = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, DEPTH + 40) : $urandom_range(0, DEPTH - 1);
      a   = 32'(idx * 4 + $urandom_range(0, 3));
      access($urandom_range(0, 1), $urandom_range(0, 1), a, $urandom, 3'($urandom_range(0, 7)), r, e);
    end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_fill();
    test_store_load();
    test_byte_lanes();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
